// File: rtl/gsim_seq_solver.sv
// gsim_seq_solver
// Sequential Gauss-Seidel solver for up to 31 back-to-back N x N systems
// A*x = b held in a shared memory. One time-shared MAC walks each row, an
// update step forms the new x_i with a saturating fixed-point multiply by the
// stored reciprocal, and sweeps repeat until the largest per-sweep change is
// within tolerance or the sweep cap is reached. Results stream out on x port.
//
// Ports:
//   i_clk, i_reset         clock, asynchronous active-high reset
//   i_module_en            start request, rising-edge qualified in IDLE
//   i_matrix_num, i_tol    matrix count and tolerance, sampled at start
//   o_proc_done            one-cycle pulse after the last result write
//   o_mem_rreq/o_mem_addr  memory read request and address
//   i_mem_rrdy             request accepted when high with o_mem_rreq
//   i_mem_dout(_vld)       read data and its valid strobe
//   o_x_wen/addr/data      result write port
module gsim_seq_solver #(
    parameter int N        = 16,
    parameter int A_W      = 16,
    parameter int A_FRAC   = 8,
    parameter int R_FRAC   = 14,
    parameter int X_W      = 32,
    parameter int MAX_ITER = 16,
    parameter int MEM_AW   = 10,
    parameter int XA_W     = 9
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_module_en,
    input  logic [4:0]        i_matrix_num,
    input  logic [X_W-1:0]    i_tol,
    output logic              o_proc_done,
    output logic              o_mem_rreq,
    output logic [MEM_AW-1:0] o_mem_addr,
    input  logic              i_mem_rrdy,
    input  logic [N*A_W-1:0]  i_mem_dout,
    input  logic              i_mem_dout_vld,
    output logic              o_x_wen,
    output logic [XA_W-1:0]   o_x_addr,
    output logic [X_W-1:0]    o_x_data
);
    localparam int X_FRAC = 16;
    localparam int IW     = (N > 1) ? $clog2(N) : 1;
    localparam int SW     = $clog2(MAX_ITER + 1);
    localparam int ACC_W  = X_W + A_W + 4;
    localparam int RW     = ACC_W + 1;
    localparam int MW     = A_W + X_W;
    localparam int PW     = RW + A_W;
    localparam int DW     = X_W + 1;

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD_B, S_ROW_REQ, S_ROW_WAIT, S_MAC,
        S_UPDATE, S_CHECK, S_WRITE, S_DONE
    } state_t;

    state_t                   state_q, state_d;
    logic                     en_low_q, en_low_d;
    logic                     load_acc_q, load_acc_d;
    logic [4:0]               mat_num_q, mat_num_d;
    logic [4:0]               mat_idx_q, mat_idx_d;
    logic [X_W-1:0]           tol_q, tol_d;
    logic [MEM_AW-1:0]        base_q, base_d;
    logic [XA_W-1:0]          xbase_q, xbase_d;
    logic [IW-1:0]            row_idx_q, row_idx_d;
    logic [IW-1:0]            col_idx_q, col_idx_d;
    logic [SW-1:0]            sweep_q, sweep_d;
    logic [N*A_W-1:0]         b_vec_q, b_vec_d;
    logic [N*A_W-1:0]         a_vec_q, a_vec_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [DW-1:0]            max_delta_q, max_delta_d;
    logic signed [X_W-1:0]    x_q [N];
    logic signed [X_W-1:0]    x_d [N];

    logic                     clear_matrix;
    logic signed [A_W-1:0]    a_sel, b_sel, recip_sel;
    logic signed [MW-1:0]     mac_prod;
    logic signed [ACC_W-1:0]  mac_term;
    logic signed [RW-1:0]     resid;
    logic signed [PW-1:0]     upd_prod, x_full;
    logic signed [X_W-1:0]    x_new;
    logic signed [DW-1:0]     diff;
    logic [DW-1:0]            delta;

    // Datapath: one MAC term for the current column, and the row update
    // (residual times reciprocal, floored, saturated) plus its change size.
    always_comb begin
        a_sel     = a_vec_q[col_idx_q*A_W +: A_W];
        b_sel     = b_vec_q[row_idx_q*A_W +: A_W];
        recip_sel = a_vec_q[row_idx_q*A_W +: A_W];
        mac_prod  = MW'(a_sel) * MW'(x_q[col_idx_q]);
        mac_term  = ACC_W'(mac_prod) >>> A_FRAC;
        resid     = (RW'(b_sel) <<< X_FRAC) - RW'(acc_q);
        upd_prod  = PW'(resid) * PW'(recip_sel);
        x_full    = upd_prod >>> R_FRAC;
        // The value fits only if every bit above the X_W sign bit matches it.
        if ((x_full[PW-1:X_W-1] == '0) || (x_full[PW-1:X_W-1] == '1)) begin
            x_new = x_full[X_W-1:0];
        end else if (x_full[PW-1]) begin
            x_new = {1'b1, {(X_W-1){1'b0}}};
        end else begin
            x_new = {1'b0, {(X_W-1){1'b1}}};
        end
        diff  = DW'(x_new) - DW'(x_q[row_idx_q]);
        delta = diff[DW-1] ? -diff : diff;
    end

    // Next-state and output logic. Outputs are decoded from the registered
    // state so an asynchronous reset clears them in the same instant.
    always_comb begin
        state_d      = state_q;
        en_low_d     = ~i_module_en;
        load_acc_d   = load_acc_q;
        mat_num_d    = mat_num_q;
        mat_idx_d    = mat_idx_q;
        tol_d        = tol_q;
        base_d       = base_q;
        xbase_d      = xbase_q;
        row_idx_d    = row_idx_q;
        col_idx_d    = col_idx_q;
        sweep_d      = sweep_q;
        b_vec_d      = b_vec_q;
        a_vec_d      = a_vec_q;
        acc_d        = acc_q;
        max_delta_d  = max_delta_q;
        x_d          = x_q;
        clear_matrix = 1'b0;
        o_proc_done  = 1'b0;
        o_mem_rreq   = 1'b0;
        o_mem_addr   = '0;
        o_x_wen      = 1'b0;
        o_x_addr     = '0;
        o_x_data     = '0;

        case (state_q)
            S_IDLE: begin
                // en_low_q is only set once enable has been seen low after
                // reset, so a level held high through reset cannot start us.
                if (i_module_en && en_low_q) begin
                    mat_num_d = i_matrix_num;
                    tol_d     = i_tol;
                    mat_idx_d = '0;
                    base_d    = '0;
                    xbase_d   = '0;
                    if (i_matrix_num == 5'd0) begin
                        state_d = S_DONE;
                    end else begin
                        clear_matrix = 1'b1;
                        state_d      = S_LOAD_B;
                    end
                end
            end
            S_LOAD_B: begin
                // Request phase until accepted, then wait for the b vector.
                o_mem_rreq = ~load_acc_q;
                o_mem_addr = load_acc_q ? '0 : base_q;
                if (!load_acc_q) begin
                    load_acc_d = i_mem_rrdy;
                end else if (i_mem_dout_vld) begin
                    b_vec_d   = i_mem_dout;
                    row_idx_d = '0;
                    state_d   = S_ROW_REQ;
                end
            end
            S_ROW_REQ: begin
                o_mem_rreq = 1'b1;
                o_mem_addr = base_q + MEM_AW'(row_idx_q) + MEM_AW'(1);
                if (i_mem_rrdy) begin
                    state_d = S_ROW_WAIT;
                end
            end
            S_ROW_WAIT: begin
                if (i_mem_dout_vld) begin
                    a_vec_d   = i_mem_dout;
                    acc_d     = '0;
                    col_idx_d = '0;
                    state_d   = S_MAC;
                end
            end
            S_MAC: begin
                // The diagonal slot holds the reciprocal, not a coefficient.
                if (col_idx_q != row_idx_q) begin
                    acc_d = acc_q + mac_term;
                end
                if (col_idx_q == IW'(N-1)) begin
                    state_d = S_UPDATE;
                end else begin
                    col_idx_d = col_idx_q + IW'(1);
                end
            end
            S_UPDATE: begin
                x_d[row_idx_q] = x_new;
                if (delta > max_delta_q) begin
                    max_delta_d = delta;
                end
                if (row_idx_q == IW'(N-1)) begin
                    state_d = S_CHECK;
                end else begin
                    row_idx_d = row_idx_q + IW'(1);
                    state_d   = S_ROW_REQ;
                end
            end
            S_CHECK: begin
                sweep_d = sweep_q + SW'(1);
                if ((sweep_q + SW'(1) == SW'(MAX_ITER)) ||
                    (max_delta_q <= {1'b0, tol_q})) begin
                    col_idx_d = '0;
                    state_d   = S_WRITE;
                end else begin
                    max_delta_d = '0;
                    row_idx_d   = '0;
                    state_d     = S_ROW_REQ;
                end
            end
            S_WRITE: begin
                // col_idx_q doubles as the result index while streaming out.
                o_x_wen  = 1'b1;
                o_x_addr = xbase_q + XA_W'(col_idx_q);
                o_x_data = x_q[col_idx_q];
                if (col_idx_q == IW'(N-1)) begin
                    mat_idx_d = mat_idx_q + 5'd1;
                    if (mat_idx_q + 5'd1 == mat_num_q) begin
                        state_d = S_DONE;
                    end else begin
                        base_d       = base_q + MEM_AW'(N+1);
                        xbase_d      = xbase_q + XA_W'(N);
                        clear_matrix = 1'b1;
                        state_d      = S_LOAD_B;
                    end
                end else begin
                    col_idx_d = col_idx_q + IW'(1);
                end
            end
            S_DONE: begin
                o_proc_done = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Each matrix starts from x = 0 with fresh sweep bookkeeping.
        if (clear_matrix) begin
            for (int k = 0; k < N; k++) begin
                x_d[k] = '0;
            end
            sweep_d     = '0;
            max_delta_d = '0;
            load_acc_d  = 1'b0;
            row_idx_d   = '0;
        end
    end

    // State register with asynchronous clear of everything.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= S_IDLE;
            en_low_q    <= 1'b0;
            load_acc_q  <= 1'b0;
            mat_num_q   <= '0;
            mat_idx_q   <= '0;
            tol_q       <= '0;
            base_q      <= '0;
            xbase_q     <= '0;
            row_idx_q   <= '0;
            col_idx_q   <= '0;
            sweep_q     <= '0;
            b_vec_q     <= '0;
            a_vec_q     <= '0;
            acc_q       <= '0;
            max_delta_q <= '0;
            for (int k = 0; k < N; k++) begin
                x_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            en_low_q    <= en_low_d;
            load_acc_q  <= load_acc_d;
            mat_num_q   <= mat_num_d;
            mat_idx_q   <= mat_idx_d;
            tol_q       <= tol_d;
            base_q      <= base_d;
            xbase_q     <= xbase_d;
            row_idx_q   <= row_idx_d;
            col_idx_q   <= col_idx_d;
            sweep_q     <= sweep_d;
            b_vec_q     <= b_vec_d;
            a_vec_q     <= a_vec_d;
            acc_q       <= acc_d;
            max_delta_q <= max_delta_d;
            x_q         <= x_d;
        end
    end

endmodule

// File: tb/tb_gsim_seq_solver.sv
// Directed bench for gsim_seq_solver with N=4 and a 4-sweep cap. A memory
// responder with configurable stall and latency serves reads; monitors log
// result writes and done pulses; a small reference model gives the expected
// results for the non-trivial matrices.
module tb_gsim_seq_solver;
    localparam int N        = 4;
    localparam int A_W      = 16;
    localparam int A_FRAC   = 8;
    localparam int R_FRAC   = 14;
    localparam int X_W      = 32;
    localparam int MAX_ITER = 4;
    localparam int MEM_AW   = 10;
    localparam int XA_W     = 9;

    logic              clk = 1'b0;
    logic              i_reset;
    logic              i_module_en;
    logic [4:0]        i_matrix_num;
    logic [X_W-1:0]    i_tol;
    logic              o_proc_done;
    logic              o_mem_rreq;
    logic [MEM_AW-1:0] o_mem_addr;
    logic              i_mem_rrdy;
    logic [N*A_W-1:0]  i_mem_dout;
    logic              i_mem_dout_vld;
    logic              o_x_wen;
    logic [XA_W-1:0]   o_x_addr;
    logic [X_W-1:0]    o_x_data;

    always #5 clk = ~clk;

    gsim_seq_solver #(
        .N(N), .A_W(A_W), .A_FRAC(A_FRAC), .R_FRAC(R_FRAC), .X_W(X_W),
        .MAX_ITER(MAX_ITER), .MEM_AW(MEM_AW), .XA_W(XA_W)
    ) dut (
        .i_clk(clk), .i_reset(i_reset), .i_module_en(i_module_en),
        .i_matrix_num(i_matrix_num), .i_tol(i_tol), .o_proc_done(o_proc_done),
        .o_mem_rreq(o_mem_rreq), .o_mem_addr(o_mem_addr), .i_mem_rrdy(i_mem_rrdy),
        .i_mem_dout(i_mem_dout), .i_mem_dout_vld(i_mem_dout_vld),
        .o_x_wen(o_x_wen), .o_x_addr(o_x_addr), .o_x_data(o_x_data)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [N*A_W-1:0] mem [0:63];
    int     mb [0:1][0:3];
    int     ma [0:1][0:3][0:3];
    longint ex [0:7];

    logic [31:0] res [0:511];
    int wr_cnt = 0, last_wr_cyc = 0, done_cnt = 0, done_cyc = 0;
    int rd_cnt = 0, vld_cnt = 0, addr_glitch = 0;
    int rd_addr [0:255];
    int stall_cfg = 0, lat_cfg = 1;

    int  lat_cnt, stall_cnt, acc_addr, data_addr;
    bit  accept_pending, req_wait;
    logic [MEM_AW-1:0] held_addr;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory responder: inputs change on the falling edge so the DUT sees
    // them settled at the next rising edge.
    always @(negedge clk) begin
        if (i_reset) begin
            accept_pending = 0; req_wait = 0; lat_cnt = 0; stall_cnt = 0;
            i_mem_dout_vld = 1'b0; i_mem_dout = '0;
            i_mem_rrdy = (stall_cfg == 0);
        end else begin
            if (accept_pending) begin
                if (rd_cnt < 256) rd_addr[rd_cnt] = acc_addr;
                rd_cnt++;
                data_addr = acc_addr;
                lat_cnt = lat_cfg;
                accept_pending = 0;
            end
            i_mem_dout_vld = 1'b0;
            if (lat_cnt > 0) begin
                lat_cnt--;
                if (lat_cnt == 0) begin
                    i_mem_dout_vld = 1'b1;
                    i_mem_dout = mem[data_addr % 64];
                    vld_cnt++;
                end
            end
            if (req_wait && (!o_mem_rreq || o_mem_addr !== held_addr)) addr_glitch++;
            req_wait = 0;
            if (o_mem_rreq) begin
                if (stall_cnt < stall_cfg) begin
                    i_mem_rrdy = 1'b0; stall_cnt++; req_wait = 1; held_addr = o_mem_addr;
                end else begin
                    i_mem_rrdy = 1'b1; accept_pending = 1; acc_addr = int'(o_mem_addr);
                    stall_cnt = 0;
                end
            end else begin
                i_mem_rrdy = (stall_cfg == 0);
                stall_cnt = 0;
            end
        end
    end

    // Write and done monitors.
    always @(negedge clk) begin
        if (o_x_wen) begin
            res[o_x_addr] = o_x_data;
            wr_cnt++;
            last_wr_cyc = cyc;
        end
        if (o_proc_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic loadMatrix(input int m, input int b0, input int b1, input int b2,
                              input int b3, input int recip, input int off);
        int bv [4];
        logic [N*A_W-1:0] w;
        logic [15:0] e;
        bv[0] = b0; bv[1] = b1; bv[2] = b2; bv[3] = b3;
        w = '0;
        for (int i = 0; i < N; i++) begin
            e = bv[i][15:0];
            w[i*A_W +: A_W] = e;
            mb[m][i] = bv[i];
        end
        mem[m*(N+1)] = w;
        for (int i = 0; i < N; i++) begin
            w = '0;
            for (int j = 0; j < N; j++) begin
                ma[m][i][j] = (i == j) ? recip : off;
                e = ma[m][i][j][15:0];
                w[j*A_W +: A_W] = e;
            end
            mem[m*(N+1)+1+i] = w;
        end
    endtask

    // Reference Gauss-Seidel in 64-bit integers; returns the sweep count.
    function automatic int runModel(input int m, input longint tol);
        longint x [4];
        longint acc, r, xn, d, maxd;
        int sw;
        for (int i = 0; i < N; i++) x[i] = 0;
        sw = 0;
        do begin
            maxd = 0;
            for (int i = 0; i < N; i++) begin
                acc = 0;
                for (int j = 0; j < N; j++)
                    if (j != i) acc += (longint'(ma[m][i][j]) * x[j]) >>> A_FRAC;
                r  = (longint'(mb[m][i]) <<< 16) - acc;
                xn = (r * longint'(ma[m][i][i])) >>> R_FRAC;
                if (xn > 64'sd2147483647) xn = 64'sd2147483647;
                if (xn < -64'sd2147483648) xn = -64'sd2147483648;
                d = xn - x[i];
                if (d < 0) d = -d;
                if (d > maxd) maxd = d;
                x[i] = xn;
            end
            sw++;
        end while (!(sw == MAX_ITER || maxd <= tol));
        for (int i = 0; i < N; i++) ex[m*N+i] = x[i];
        return sw;
    endfunction

    // Start a job on a fresh enable edge and wait (bounded) for its done pulse.
    task automatic applyStimulus(input int m_num, input logic [31:0] tol, output int start_cyc);
        int d0;
        int k;
        d0 = done_cnt;
        @(negedge clk);
        i_matrix_num = m_num[4:0];
        i_tol = tol;
        i_module_en = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        @(negedge clk);
        i_module_en = 1'b0;
        i_matrix_num = 5'd7;
        i_tol = 32'hFFFF_FFFF;
        k = 0;
        while (done_cnt == d0 && k < 4000) begin
            @(negedge clk);
            k++;
        end
        checkOutput("done_seen", 64'(done_cnt != d0), 64'd1);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int sc, r0, w0, d0, v0, sw, k;
        logic [63:0] tv [0:3];
        i_reset = 1'b1; i_module_en = 1'b0; i_matrix_num = '0; i_tol = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_rreq", 64'(o_mem_rreq), 64'd0);
        checkOutput("reset_wen", 64'(o_x_wen), 64'd0);
        checkOutput("reset_done", 64'(o_proc_done), 64'd0);
        checkOutput("reset_buses", {o_mem_addr, o_x_addr, o_x_data}, 64'd0);
        i_reset = 1'b0;
        repeat (3) @(negedge clk);

        $display("[TB] trivial converge");
        tv[0] = 64'h0001_0000; tv[1] = 64'h0002_0000; tv[2] = 64'hFFFD_0000; tv[3] = 64'h0004_0000;
        loadMatrix(0, 1, 2, -3, 4, 32'h4000, 0);
        r0 = rd_cnt; d0 = done_cnt; w0 = wr_cnt;
        applyStimulus(1, 32'd0, sc);
        checkOutput("triv_reads", 64'(rd_cnt - r0), 64'd9);
        for (int i = 0; i < N; i++) checkOutput($sformatf("triv_x%0d", i), 64'(res[i]), tv[i]);
        checkOutput("triv_writes", 64'(wr_cnt - w0), 64'd4);
        checkOutput("triv_done_cnt", 64'(done_cnt - d0), 64'd1);
        checkOutput("triv_done_after_write", 64'(done_cyc), 64'(last_wr_cyc + 1));

        $display("[TB] zero matrices");
        r0 = rd_cnt; w0 = wr_cnt; d0 = done_cnt;
        applyStimulus(0, 32'd0, sc);
        checkOutput("m0_done_latency", 64'(done_cyc), 64'(sc + 1));
        checkOutput("m0_no_reads", 64'(rd_cnt - r0), 64'd0);
        checkOutput("m0_no_writes", 64'(wr_cnt - w0), 64'd0);

        $display("[TB] iteration cap");
        loadMatrix(0, 10, -7, 3, 12, 32'h0CCD, -256);
        sw = runModel(0, 0);
        r0 = rd_cnt;
        applyStimulus(1, 32'd0, sc);
        checkOutput("cap_reads", 64'(rd_cnt - r0), 64'(1 + MAX_ITER*4));
        for (int i = 0; i < N; i++) checkOutput($sformatf("cap_x%0d", i), 64'(res[i]), 64'(ex[i][31:0]));

        $display("[TB] backpressure and latency");
        stall_cfg = 5; lat_cfg = 3;
        r0 = rd_cnt; w0 = wr_cnt; v0 = addr_glitch;
        applyStimulus(1, 32'd0, sc);
        checkOutput("bp_reads", 64'(rd_cnt - r0), 64'(1 + MAX_ITER*4));
        checkOutput("bp_writes", 64'(wr_cnt - w0), 64'd4);
        checkOutput("bp_addr_stable", 64'(addr_glitch - v0), 64'd0);
        for (int i = 0; i < N; i++) checkOutput($sformatf("bp_x%0d", i), 64'(res[i]), 64'(ex[i][31:0]));
        stall_cfg = 0; lat_cfg = 1;
        repeat (2) @(negedge clk);

        $display("[TB] tolerance early exit");
        sw = runModel(0, 64'h0010_0000);
        r0 = rd_cnt;
        applyStimulus(1, 32'h0010_0000, sc);
        checkOutput("tol_reads", 64'(rd_cnt - r0), 64'd5);
        for (int i = 0; i < N; i++) checkOutput($sformatf("tol_x%0d", i), 64'(res[i]), 64'(ex[i][31:0]));

        $display("[TB] multi-matrix");
        loadMatrix(0, 1, 2, -3, 4, 32'h4000, 0);
        loadMatrix(1, 5, -6, 7, -8, 32'h4000, 0);
        r0 = rd_cnt; w0 = wr_cnt; d0 = done_cnt;
        applyStimulus(2, 32'd0, sc);
        checkOutput("mm_reads", 64'(rd_cnt - r0), 64'd18);
        checkOutput("mm_first_addr", 64'(rd_addr[r0]), 64'd0);
        checkOutput("mm_second_base", 64'(rd_addr[r0+9]), 64'd5);
        checkOutput("mm_writes", 64'(wr_cnt - w0), 64'd8);
        checkOutput("mm_x0", 64'(res[0]), 64'h0001_0000);
        checkOutput("mm_x4", 64'(res[4]), 64'h0005_0000);
        checkOutput("mm_x5", 64'(res[5]), 64'hFFFA_0000);
        checkOutput("mm_x6", 64'(res[6]), 64'h0007_0000);
        checkOutput("mm_x7", 64'(res[7]), 64'hFFF8_0000);
        checkOutput("mm_done_cnt", 64'(done_cnt - d0), 64'd1);
        checkOutput("mm_done_after_write", 64'(done_cyc), 64'(last_wr_cyc + 1));

        $display("[TB] saturation");
        loadMatrix(0, 32767, -32768, 0, 0, 32'h7FFF, 0);
        applyStimulus(1, 32'd0, sc);
        checkOutput("sat_pos", 64'(res[0]), 64'h7FFF_FFFF);
        checkOutput("sat_neg", 64'(res[1]), 64'h8000_0000);
        checkOutput("sat_zero", 64'(res[2]), 64'h0);

        $display("[TB] reset mid-MAC");
        loadMatrix(0, 1, 2, -3, 4, 32'h4000, 0);
        v0 = vld_cnt;
        @(negedge clk);
        i_matrix_num = 5'd1; i_tol = '0; i_module_en = 1'b1;
        @(negedge clk);
        i_module_en = 1'b0;
        k = 0;
        while (vld_cnt < v0 + 2 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        checkOutput("rst_row_data_seen", 64'(vld_cnt >= v0 + 2), 64'd1);
        @(negedge clk);
        d0 = done_cnt; w0 = wr_cnt;
        i_reset = 1'b1;
        #1;
        checkOutput("rst_outputs", {o_mem_rreq, o_x_wen, o_proc_done, o_mem_addr, o_x_addr, o_x_data}, 64'd0);
        repeat (3) @(negedge clk);
        i_reset = 1'b0;
        repeat (30) @(negedge clk);
        checkOutput("rst_no_done", 64'(done_cnt - d0), 64'd0);
        checkOutput("rst_no_writes", 64'(wr_cnt - w0), 64'd0);
        r0 = rd_cnt; w0 = wr_cnt;
        applyStimulus(1, 32'd0, sc);
        checkOutput("rst_rerun_reads", 64'(rd_cnt - r0), 64'd9);
        checkOutput("rst_rerun_writes", 64'(wr_cnt - w0), 64'd4);
        for (int i = 0; i < N; i++) checkOutput($sformatf("rst_rerun_x%0d", i), 64'(res[i]), tv[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
